// File: rtl/mnist_pio_pkg.sv
// Shared constants and FSM encoding for the HPS<->FPGA PIO responder.
// Image geometry (28x28 words), bus widths and the handshake state set live here.
package mnist_pio_pkg;

  localparam int N_WORDS = 784;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 20;
  localparam int CLASS_W = 4;
  localparam int CNT_W   = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ACK   = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Only addresses inside the image land in the input buffer.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < CNT_W'(N_WORDS);
  endfunction

endpackage

// File: rtl/pio_sync2.sv
// Two-flop synchronizer for single-bit HPS control lines crossing into clk.
// Cleared by the system reset only, so a synchronised soft reset cannot hold itself.
module pio_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hps_pio_responder.sv
// FPGA end of the HPS PIO 4-phase handshake: loads one image into the CNN input buffer,
// starts inference, and returns the class. Define HPS_SYNC_EN to synchronise hps_valid/hps_reset.
module hps_pio_responder
  import mnist_pio_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               hps_reset,
  input  logic               hps_valid,
  input  logic [ADDR_W-1:0]  hps_input_addr,
  input  logic [DATA_W-1:0]  hps_input_data,
  output logic               fpga_ack,
  output logic               fpga_done,
  output logic [CLASS_W-1:0] fpga_output_data,
  output logic               buf_we,
  output logic [ADDR_W-1:0]  buf_waddr,
  output logic [DATA_W-1:0]  buf_wdata,
  output logic               cnn_start,
  input  logic               cnn_done,
  input  logic [CLASS_W-1:0] cnn_class
);

  logic valid_s;
  logic hps_reset_s;
  logic rst;

`ifdef HPS_SYNC_EN
  // addr/data are stable by protocol while valid is high, so only the controls cross.
  pio_sync2 u_sync_valid (
    .clk   (clk),
    .reset (reset),
    .d     (hps_valid),
    .q     (valid_s)
  );

  pio_sync2 u_sync_reset (
    .clk   (clk),
    .reset (reset),
    .d     (hps_reset),
    .q     (hps_reset_s)
  );
`else
  assign valid_s     = hps_valid;
  assign hps_reset_s = hps_reset;
`endif

  assign rst = reset | hps_reset_s;

  state_t           state;
  logic [CNT_W-1:0] count;

  // NOTE: reset is synchronous here, so it lives inside the clocked block; all state
  // uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      fpga_ack         <= 1'b0;
      fpga_done        <= 1'b0;
      fpga_output_data <= '0;
      buf_we           <= 1'b0;
      buf_waddr        <= '0;
      buf_wdata        <= '0;
      cnn_start        <= 1'b0;
    end else begin
      buf_we    <= 1'b0;
      cnn_start <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_s) begin
            buf_waddr <= hps_input_addr;
            buf_wdata <= hps_input_data;
            // The strobe is registered on entry so it is high for exactly the WRITE cycle.
            if (addr_in_range(hps_input_addr)) begin
              buf_we <= 1'b1;
              count  <= count + CNT_W'(1);
            end
            state <= WRITE;
          end
        end

        WRITE: begin
          fpga_ack <= 1'b1;
          state    <= ACK;
        end

        ACK: begin
          if (!valid_s) begin
            fpga_ack <= 1'b0;
            if (count == CNT_W'(N_WORDS)) begin
              cnn_start <= 1'b1;
              state     <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end

        RUN: begin
          if (cnn_done) begin
            fpga_done        <= 1'b1;
            fpga_output_data <= cnn_class;
            state            <= DONE;
          end
        end

        DONE: begin
          // Result is held until the next reset.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
